// File: rtl/vram_painter_pkg.sv
// vram_painter_pkg: shared constants and FSM state type for the VRAM painter
package vram_painter_pkg;
   localparam int RGB_W = 12;
   localparam int HW_DEF = 256;
   localparam int VH_DEF = 192;
   localparam logic [RGB_W-1:0] BG_DEF = 12'hFFF;
   typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/vram_painter_if.sv
// vram_painter_if: operator buttons in, cursor and VRAM write port out
interface vram_painter_if import vram_painter_pkg::*; #(
   parameter int XW = 8,
   parameter int YW = 8,
   parameter int AW = 16
);
   logic btn_u, btn_d, btn_l, btn_r, draw, clr;
   logic [RGB_W-1:0] color;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic we;
   logic [AW-1:0] waddr;
   logic [RGB_W-1:0] wdata;
   logic busy;
   modport master (
      output btn_u, btn_d, btn_l, btn_r, draw, clr, color,
      input cur_x, cur_y, we, waddr, wdata, busy
   );
   modport slave (
      input btn_u, btn_d, btn_l, btn_r, draw, clr, color,
      output cur_x, cur_y, we, waddr, wdata, busy
   );
endinterface

// File: rtl/vram_painter_btn_repeat.sv
// btn_repeat: synchronise a button, pulse on press, then auto-repeat while held
module btn_repeat #(
   parameter int HOLD_CYC = 5_000_000,
   parameter int REP_CYC = 1_000_000
) (
   input logic clk,
   input logic rst,
   input logic btn,
   output logic step
);
   localparam int MX = HOLD_CYC > REP_CYC ? HOLD_CYC : REP_CYC;
   localparam int CW = $clog2(MX + 1);
   localparam logic [CW-1:0] HOLD_N = CW'(HOLD_CYC);
   localparam logic [CW-1:0] REP_N = CW'(REP_CYC);
   logic [2:0] sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic rep_q, rep_d;
   // sync_q[1] is the synchronised level, sync_q[2] its previous value; cnt counts cycles since the last pulse
   always_comb begin
      sync_d = {sync_q[1:0], btn};
      cnt_d = cnt_q + 1'b1;
      rep_d = rep_q;
      step = 1'b0;
      if (!sync_q[1]) begin
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (!sync_q[2] || cnt_q == (rep_q ? REP_N : HOLD_N)) begin
         step = 1'b1;
         cnt_d = CW'(1);
         rep_d = sync_q[2];
      end
   end
   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q <= cnt_d;
         rep_q <= rep_d;
      end
   end
endmodule

// File: rtl/vram_painter.sv
// vram_painter: cursor movement, paint writes and full-frame clear sweep into VRAM
module vram_painter import vram_painter_pkg::*; #(
   parameter int HW = HW_DEF,
   parameter int VH = VH_DEF,
   parameter int XW = 8,
   parameter int YW = 8,
   parameter int AW = 16,
   parameter logic [RGB_W-1:0] BG_COLOR = BG_DEF,
   parameter int HOLD_CYC = 5_000_000,
   parameter int REP_CYC = 1_000_000
) (
   input logic clk,
   input logic rst,
   vram_painter_if.slave bus
);
   localparam logic [XW-1:0] X_MAX = XW'(HW - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(VH - 1);
   localparam logic [AW-1:0] LAST = AW'(HW * VH - 1);
   logic step_u, step_d, step_l, step_r;
   logic go_u, go_d, go_l, go_r;
   state_t state_q, state_d;
   logic [2:0] draw_q, draw_d, clr_q, clr_d;
   logic [XW-1:0] cur_x_q, cur_x_d;
   logic [YW-1:0] cur_y_q, cur_y_d;
   logic we_q, we_d, busy_q, busy_d, moved_q, moved_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [RGB_W-1:0] wdata_q, wdata_d;

   btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_up (.clk(clk), .rst(rst), .btn(bus.btn_u), .step(step_u));
   btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_dn (.clk(clk), .rst(rst), .btn(bus.btn_d), .step(step_d));
   btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_lf (.clk(clk), .rst(rst), .btn(bus.btn_l), .step(step_l));
   btn_repeat #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_rt (.clk(clk), .rst(rst), .btn(bus.btn_r), .step(step_r));

   // next state: the sweep uses waddr itself as its counter; opposing steps cancel and border steps are dropped
   always_comb begin
      draw_d = {draw_q[1:0], bus.draw};
      clr_d = {clr_q[1:0], bus.clr};
      go_r = step_r & ~step_l & (cur_x_q != X_MAX);
      go_l = step_l & ~step_r & (cur_x_q != '0);
      go_d = step_d & ~step_u & (cur_y_q != Y_MAX);
      go_u = step_u & ~step_d & (cur_y_q != '0);
      state_d = state_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      we_d = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      busy_d = busy_q;
      moved_d = 1'b0;
      if (state_q == CLEAR) begin
         if (waddr_q == LAST) begin
            state_d = IDLE;
            busy_d = 1'b0;
         end else begin
            we_d = 1'b1;
            waddr_d = waddr_q + 1'b1;
         end
      end else if (clr_q[1] & ~clr_q[2]) begin
         state_d = CLEAR;
         busy_d = 1'b1;
         we_d = 1'b1;
         waddr_d = '0;
         wdata_d = BG_COLOR;
      end else begin
         if (draw_q[1] & (~draw_q[2] | moved_q)) begin
            we_d = 1'b1;
            waddr_d = {cur_y_q, cur_x_q};
            wdata_d = bus.color;
         end
         cur_x_d = cur_x_q + XW'(go_r) - XW'(go_l);
         cur_y_d = cur_y_q + YW'(go_d) - YW'(go_u);
         moved_d = go_r | go_l | go_u | go_d;
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         draw_q <= '0;
         clr_q <= '0;
         cur_x_q <= XW'(HW / 2);
         cur_y_q <= YW'(VH / 2);
         we_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         busy_q <= 1'b0;
         moved_q <= 1'b0;
      end else begin
         state_q <= state_d;
         draw_q <= draw_d;
         clr_q <= clr_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         we_q <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         busy_q <= busy_d;
         moved_q <= moved_d;
      end
   end

   assign bus.cur_x = cur_x_q;
   assign bus.cur_y = cur_y_q;
   assign bus.we = we_q;
   assign bus.waddr = waddr_q;
   assign bus.wdata = wdata_q;
   assign bus.busy = busy_q;
endmodule
